masked_bv4_inv_out: RTL and testbench

- Downstream neighbour of the masked Theta stage inside the masked GF(2^4) inverter of the tower-field S-box.
- Takes the masked 4-bit input Gamma = {Gamma_1, Gamma_0} and the masked 2-bit Theta that the Theta stage produced from the same Gamma.
- Forms the masked inverse halves with two HPC3 multiplications: out_hi = Theta * Gamma_0, out_lo = Theta * Gamma_1.
- Re-joins the halves into a bv4_t share vector and tracks validity through the pipeline.

---
 rtl/aes128_package.sv | 64 ++++++
 rtl/masked_hpc3_1_mul.sv | 67 ++++++
 rtl/masked_join_bv.sv | 16 +
 rtl/masked_split_bv.sv | 17 +
 rtl/register.sv | 23 ++
 rtl/masked_bv4_inv_out.sv | 108 ++++++++++
 tb/tb_masked_bv4_inv_out.sv | 372 +++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes128_package.sv
// Shared GF(2^4) tower-field types, constants and unmasked reference functions.
// INV_OUT_LATENCY follows the MASKED_BV4_INV_OUT_REG_EN build macro.
package aes128_package;

    typedef logic [1:0] bv2_t;
    typedef logic [3:0] bv4_t;

`ifdef MASKED_BV4_INV_OUT_REG_EN
    localparam int INV_OUT_LATENCY = 3;
`else
    localparam int INV_OUT_LATENCY = 2;
`endif

    function automatic int num_quad(input int num_shares);
        return num_shares * (num_shares - 1) / 2;
    endfunction

    // Dense index of the unordered share pair {i, j}, i != j.
    function automatic int pair_index(input int i, input int j, input int num_shares);
        int lo;
        int hi;
        int idx;
        lo  = (i < j) ? i : j;
        hi  = (i < j) ? j : i;
        idx = 0;
        for (int a = 0; a < lo; a++) begin
            idx += num_shares - 1 - a;
        end
        return idx + (hi - lo - 1);
    endfunction

    // GF(2^2) product in the normal basis {W^2, W}; one is 2'b11.
    function automatic bv2_t bv2_mul_ref(input bv2_t x, input bv2_t y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    // Scaling by N = W^2.
    function automatic bv2_t bv2_scl_n_ref(input bv2_t x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic bv4_t bv4_mul_ref(input bv4_t x, input bv4_t y);
        bv2_t e;
        e = bv2_scl_n_ref(bv2_mul_ref(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {bv2_mul_ref(x[3:2], y[3:2]) ^ e, bv2_mul_ref(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic bv4_t bv4_inv_ref(input bv4_t x);
        bv2_t a;
        bv2_t b;
        bv2_t s;
        bv2_t c;
        bv2_t e;
        a = x[3:2];
        b = x[1:0];
        s = a ^ b;
        c = bv2_scl_n_ref({s[0], s[1]}) ^ bv2_mul_ref(a, b);
        e = {c[0], c[1]};
        return {bv2_mul_ref(e, b), bv2_mul_ref(e, a)};
    endfunction

endpackage

// File: rtl/masked_hpc3_1_mul.sv
// First-order-composable HPC3 masked multiplier over GF(2^2) (normal basis), one-cycle latency.
module masked_hpc3_1_mul
    import aes128_package::*;
#(
    parameter  int NUM_SHARES    = 2,
    parameter  int BIT_WIDTH     = 2,
    localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
    input  logic                                       in_clock,
    input  logic                                       in_reset,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       in_a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       in_b,
    input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]    in_r,
    input  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0]    in_p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       out_c
);

    function automatic logic [BIT_WIDTH-1:0] field_mul(input logic [BIT_WIDTH-1:0] x,
                                                       input logic [BIT_WIDTH-1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [BIT_WIDTH-1:0] xor_row(
        input logic [NUM_SHARES-2:0][BIT_WIDTH-1:0] row);
        logic [BIT_WIDTH-1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_SHARES - 1; k++) begin
            acc ^= row[k];
        end
        return acc;
    endfunction

    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   w_diag;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0]   w_cross;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0]   w_blind;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   r_diag;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0]   r_cross;
    logic [NUM_SHARES-1:0][NUM_SHARES-2:0][BIT_WIDTH-1:0]   r_blind;

    // Row k of share i pairs with share j = k (k < i) or k + 1; r and p are shared by (i,j) and (j,i)
    // so they cancel in the recombined sum. ~a equals a + 1 because one is 2'b11 in this basis.
    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
        assign w_diag[i] = field_mul(in_a[i], in_b[i]);
        for (genvar k = 0; k < NUM_SHARES - 1; k++) begin : g_pair
            localparam int J = (k < i) ? k : k + 1;
            localparam int Q = pair_index(i, J, NUM_SHARES);
            assign w_cross[i][k] = field_mul(in_a[i], in_b[J] ^ in_r[Q]);
            assign w_blind[i][k] = field_mul(~in_a[i], in_r[Q]) ^ in_p[Q];
        end
        assign out_c[i] = r_diag[i] ^ xor_row(r_cross[i]) ^ xor_row(r_blind[i]);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_diag  <= '0;
            r_cross <= '0;
            r_blind <= '0;
        end else begin
            r_diag  <= w_diag;
            r_cross <= w_cross;
            r_blind <= w_blind;
        end
    end

endmodule

// File: rtl/masked_join_bv.sv
// Concatenates high and low bv2_t share vectors back into one bv4_t share vector.
module masked_join_bv
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2
) (
    input  bv2_t [NUM_SHARES-1:0] in_hi,
    input  bv2_t [NUM_SHARES-1:0] in_lo,
    output bv4_t [NUM_SHARES-1:0] out_x
);

    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
        assign out_x[i] = {in_hi[i], in_lo[i]};
    end

endmodule

// File: rtl/masked_split_bv.sv
// Splits a bv4_t share vector into its high and low bv2_t share vectors.
module masked_split_bv
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2
) (
    input  bv4_t [NUM_SHARES-1:0] in_x,
    output bv2_t [NUM_SHARES-1:0] out_hi,
    output bv2_t [NUM_SHARES-1:0] out_lo
);

    for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
        assign out_hi[i] = in_x[i][3:2];
        assign out_lo[i] = in_x[i][1:0];
    end

endmodule

// File: rtl/register.sv
// Plain pipeline register with synchronous active-high clear.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_data <= '0;
        end else begin
            r_data <= in_data;
        end
    end

    assign out_data = r_data;

endmodule

// File: rtl/masked_bv4_inv_out.sv
// Output stage of the masked GF(2^4) inverter: {Theta*Gamma_0, Theta*Gamma_1} via two HPC3 multipliers.
// Build macro MASKED_BV4_INV_OUT_REG_EN adds one output register (latency 3 instead of 2).
module masked_bv4_inv_out
    import aes128_package::*;
#(
    parameter  int NUM_SHARES    = 2,
    localparam int NUM_QUADRATIC = num_quad(NUM_SHARES),
    localparam int NUM_RANDOM    = 2 * 2 * (NUM_QUADRATIC * 2)
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  bv4_t [NUM_SHARES-1:0]   in_gamma,
    input  bv2_t [NUM_SHARES-1:0]   in_theta,
    input  logic [NUM_RANDOM-1:0]   in_random,
    input  logic                    in_valid,
    output bv4_t [NUM_SHARES-1:0]   out_b,
    output logic                    out_valid
);

    localparam int RW = NUM_QUADRATIC * 2;

    bv2_t [NUM_SHARES-1:0]    w_gamma_hi;
    bv2_t [NUM_SHARES-1:0]    w_gamma_lo;
    bv2_t [NUM_SHARES-1:0]    w_gamma_hi_d1;
    bv2_t [NUM_SHARES-1:0]    w_gamma_lo_d1;
    bv2_t [NUM_QUADRATIC-1:0] w_r_lo;
    bv2_t [NUM_QUADRATIC-1:0] w_p_lo;
    bv2_t [NUM_QUADRATIC-1:0] w_r_hi;
    bv2_t [NUM_QUADRATIC-1:0] w_p_hi;
    bv2_t [NUM_SHARES-1:0]    w_mul_hi;
    bv2_t [NUM_SHARES-1:0]    w_mul_lo;
    bv4_t [NUM_SHARES-1:0]    w_b;
    logic [INV_OUT_LATENCY-1:0] r_valid;

    masked_split_bv #(.NUM_SHARES(NUM_SHARES)) u_split (
        .in_x   (in_gamma),
        .out_hi (w_gamma_hi),
        .out_lo (w_gamma_lo)
    );

    // Gamma arrives one cycle ahead of Theta.
    register #(.WIDTH(2 * NUM_SHARES)) u_align_hi (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_data  (w_gamma_hi),
        .out_data (w_gamma_hi_d1)
    );

    register #(.WIDTH(2 * NUM_SHARES)) u_align_lo (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_data  (w_gamma_lo),
        .out_data (w_gamma_lo_d1)
    );

    assign w_r_lo = in_random[RW-1:0];
    assign w_p_lo = in_random[2*RW-1:RW];
    assign w_r_hi = in_random[3*RW-1:2*RW];
    assign w_p_hi = in_random[4*RW-1:3*RW];

    masked_hpc3_1_mul #(.NUM_SHARES(NUM_SHARES), .BIT_WIDTH(2)) u_mul_hi (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_theta),
        .in_b     (w_gamma_lo_d1),
        .in_r     (w_r_hi),
        .in_p     (w_p_hi),
        .out_c    (w_mul_hi)
    );

    masked_hpc3_1_mul #(.NUM_SHARES(NUM_SHARES), .BIT_WIDTH(2)) u_mul_lo (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_a     (in_theta),
        .in_b     (w_gamma_hi_d1),
        .in_r     (w_r_lo),
        .in_p     (w_p_lo),
        .out_c    (w_mul_lo)
    );

    masked_join_bv #(.NUM_SHARES(NUM_SHARES)) u_join (
        .in_hi (w_mul_hi),
        .in_lo (w_mul_lo),
        .out_x (w_b)
    );

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[INV_OUT_LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = r_valid[INV_OUT_LATENCY-1];

`ifdef MASKED_BV4_INV_OUT_REG_EN
    register #(.WIDTH(4 * NUM_SHARES)) u_out_reg (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_data  (w_b),
        .out_data (out_b)
    );
`else
    assign out_b = w_b;
`endif

endmodule

// File: tb/tb_masked_bv4_inv_out.sv
// Bench for masked_bv4_inv_out: random masks/randomness, checked against unmasked GF(2^4) arithmetic.
module tb_masked_bv4_inv_out;
    import aes128_package::*;

    localparam int LAT = INV_OUT_LATENCY;
    localparam int NS2 = 2;
    localparam int NR2 = 8 * (NS2 * (NS2 - 1) / 2);
    localparam int NS3 = 3;
    localparam int NR3 = 8 * (NS3 * (NS3 - 1) / 2);

    typedef bv4_t [NS2-1:0] g2_t;
    typedef bv2_t [NS2-1:0] t2_t;
    typedef bv4_t [NS3-1:0] g3_t;
    typedef bv2_t [NS3-1:0] t3_t;

    logic clk = 1'b0;
    logic rst;
    g2_t gamma2; t2_t theta2; logic [NR2-1:0] rnd2; logic valid2; g2_t b2; logic ov2;
    g3_t gamma3; t3_t theta3; logic [NR3-1:0] rnd3; logic valid3; g3_t b3; logic ov3;

    int tests_run = 0;
    int tests_failed = 0;

    bit   seq_valid [0:63];
    bv4_t seq_gamma [0:63];
    bv2_t seq_theta [0:63];
    bit   obs_valid [0:79];
    bv4_t obs_b     [0:79];
    bit   obs_zero  [0:79];

    always #5 clk = ~clk;

    masked_bv4_inv_out #(.NUM_SHARES(NS2)) dut2 (
        .in_clock(clk), .in_reset(rst), .in_gamma(gamma2), .in_theta(theta2),
        .in_random(rnd2), .in_valid(valid2), .out_b(b2), .out_valid(ov2)
    );

    masked_bv4_inv_out #(.NUM_SHARES(NS3)) dut3 (
        .in_clock(clk), .in_reset(rst), .in_gamma(gamma3), .in_theta(theta3),
        .in_random(rnd3), .in_valid(valid3), .out_b(b3), .out_valid(ov3)
    );

    function automatic g2_t mask_g2(input bv4_t v);
        g2_t s; bv4_t acc;
        acc = v;
        for (int i = 0; i < NS2 - 1; i++) begin s[i] = bv4_t'($urandom()); acc ^= s[i]; end
        s[NS2-1] = acc;
        return s;
    endfunction

    function automatic t2_t mask_t2(input bv2_t v);
        t2_t s; bv2_t acc;
        acc = v;
        for (int i = 0; i < NS2 - 1; i++) begin s[i] = bv2_t'($urandom()); acc ^= s[i]; end
        s[NS2-1] = acc;
        return s;
    endfunction

    function automatic g3_t mask_g3(input bv4_t v);
        g3_t s; bv4_t acc;
        acc = v;
        for (int i = 0; i < NS3 - 1; i++) begin s[i] = bv4_t'($urandom()); acc ^= s[i]; end
        s[NS3-1] = acc;
        return s;
    endfunction

    function automatic t3_t mask_t3(input bv2_t v);
        t3_t s; bv2_t acc;
        acc = v;
        for (int i = 0; i < NS3 - 1; i++) begin s[i] = bv2_t'($urandom()); acc ^= s[i]; end
        s[NS3-1] = acc;
        return s;
    endfunction

    function automatic bv4_t unmask2(input g2_t s);
        bv4_t acc;
        acc = '0;
        for (int i = 0; i < NS2; i++) acc ^= s[i];
        return acc;
    endfunction

    function automatic bv4_t unmask3(input g3_t s);
        bv4_t acc;
        acc = '0;
        for (int i = 0; i < NS3; i++) acc ^= s[i];
        return acc;
    endfunction

    // GF(4) inverse by exhaustive search for y with x*y = 1 (2'b11).
    function automatic bv2_t inv2(input bv2_t x);
        bv2_t y;
        for (int k = 0; k < 4; k++) begin
            y = bv2_t'(k);
            if (bv2_mul_ref(x, y) == 2'b11) return y;
        end
        return 2'b00;
    endfunction

    // Unmasked output of the preceding Theta stage: (N*(g1+g0)^2 + g1*g0)^-1.
    function automatic bv2_t theta_of(input bv4_t g);
        bv2_t s;
        s = g[3:2] ^ g[1:0];
        return inv2(bv2_mul_ref(2'b10, bv2_mul_ref(s, s)) ^ bv2_mul_ref(g[3:2], g[1:0]));
    endfunction

    task automatic idle3();
        valid3 = 1'b0;
        gamma3 = g3_t'({$urandom(), $urandom()});
        theta3 = t3_t'($urandom());
        rnd3   = NR3'($urandom());
    endtask

    // Drives seq_* items 0..n-1 into dut2 one per cycle and records what comes out.
    task automatic run_stream2(input int n, input int reset_cycle);
        for (int c = 0; c < n + LAT; c++) begin
            @(negedge clk);
            obs_valid[c] = ov2;
            obs_b[c]     = unmask2(b2);
            obs_zero[c]  = (b2 == '0);
            rst = (c == reset_cycle);
            if (c < n) begin
                valid2 = seq_valid[c];
                gamma2 = mask_g2(seq_gamma[c]);
            end else begin
                valid2 = 1'b0;
                gamma2 = g2_t'($urandom());
            end
            if (c >= 1 && c - 1 < n) theta2 = mask_t2(seq_theta[c-1]);
            else                     theta2 = t2_t'($urandom());
            rnd2 = NR2'($urandom());
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid2 = 1'b1; gamma2 = g2_t'($urandom()); theta2 = t2_t'($urandom()); rnd2 = NR2'($urandom());
        valid3 = 1'b1; gamma3 = g3_t'({$urandom(), $urandom()}); theta3 = t3_t'($urandom()); rnd3 = NR3'($urandom());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (b2 !== '0 || ov2 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_ns2 cycle=%0d got b=%h valid=%b want b=0 valid=0", i, b2, ov2);
            end
            tests_run++;
            if (b3 !== '0 || ov3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_ns3 cycle=%0d got b=%h valid=%b want b=0 valid=0", i, b3, ov3);
            end
            gamma2 = g2_t'($urandom()); theta2 = t2_t'($urandom()); rnd2 = NR2'($urandom());
            gamma3 = g3_t'({$urandom(), $urandom()}); theta3 = t3_t'($urandom()); rnd3 = NR3'($urandom());
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ov2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got valid=%b want 0", ov2);
        end
        valid2 = 1'b0;
        idle3();
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_zero_theta();
        seq_valid[0] = 1'b1; seq_gamma[0] = 4'hB; seq_theta[0] = 2'b00;
        run_stream2(1, -1);
        for (int c = 0; c < 1 + LAT; c++) begin
            tests_run++;
            if (obs_valid[c] !== (c == LAT)) begin
                tests_failed++;
                $display("FAIL zero_theta_valid slot=%0d got %b want %b", c, obs_valid[c], (c == LAT));
            end
        end
        tests_run++;
        if (obs_b[LAT] !== 4'h0) begin
            tests_failed++;
            $display("FAIL zero_theta_data got %h want 0", obs_b[LAT]);
        end
    endtask

    task automatic test_exhaustive();
        bv4_t g;
        for (int k = 0; k < 16; k++) begin
            seq_valid[k] = 1'b1;
            seq_gamma[k] = bv4_t'(k);
            seq_theta[k] = theta_of(bv4_t'(k));
        end
        run_stream2(16, -1);
        for (int c = 0; c < LAT; c++) begin
            tests_run++;
            if (obs_valid[c] !== 1'b0) begin
                tests_failed++;
                $display("FAIL exhaustive_lead slot=%0d got valid=%b want 0", c, obs_valid[c]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            g = bv4_t'(k);
            tests_run++;
            if (obs_valid[k+LAT] !== 1'b1) begin
                tests_failed++;
                $display("FAIL exhaustive_valid g=%h got %b want 1", g, obs_valid[k+LAT]);
            end
            tests_run++;
            if (obs_b[k+LAT] !== bv4_inv_ref(g)) begin
                tests_failed++;
                $display("FAIL exhaustive_inv g=%h got %h want %h", g, obs_b[k+LAT], bv4_inv_ref(g));
            end
            tests_run++;
            if (k == 0) begin
                if (obs_b[k+LAT] !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL exhaustive_zero got %h want 0", obs_b[k+LAT]);
                end
            end else if (bv4_mul_ref(g, obs_b[k+LAT]) !== 4'hF) begin
                tests_failed++;
                $display("FAIL exhaustive_product g=%h got %h want f", g, bv4_mul_ref(g, obs_b[k+LAT]));
            end
        end
    endtask

    task automatic test_bubbles();
        bit pat [0:4];
        bit exp_v;
        int n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        n = 5;
        for (int k = 0; k < n; k++) begin
            seq_valid[k] = pat[k];
            seq_gamma[k] = bv4_t'($urandom());
            seq_theta[k] = theta_of(seq_gamma[k]);
        end
        run_stream2(n, -1);
        for (int c = 0; c < n + LAT; c++) begin
            exp_v = (c >= LAT) ? pat[c-LAT] : 1'b0;
            tests_run++;
            if (obs_valid[c] !== exp_v) begin
                tests_failed++;
                $display("FAIL bubbles_valid slot=%0d got %b want %b", c, obs_valid[c], exp_v);
            end
            if (exp_v) begin
                tests_run++;
                if (obs_b[c] !== bv4_inv_ref(seq_gamma[c-LAT])) begin
                    tests_failed++;
                    $display("FAIL bubbles_data slot=%0d got %h want %h", c, obs_b[c],
                             bv4_inv_ref(seq_gamma[c-LAT]));
                end
            end
        end
    endtask

    // Item k survives only if no reset edge falls while it is inside the pipe (edges k..k+LAT-1).
    task automatic test_mid_reset();
        int n, rc, k;
        bit exp_v;
        n  = LAT + 2;
        rc = LAT - 1;
        for (int i = 0; i < n; i++) begin
            seq_valid[i] = (i < LAT) || (i == LAT + 1);
            seq_gamma[i] = bv4_t'($urandom());
            seq_theta[i] = theta_of(seq_gamma[i]);
        end
        run_stream2(n, rc);
        for (int c = 0; c < n + LAT; c++) begin
            exp_v = 1'b0;
            if (c >= LAT) begin
                k = c - LAT;
                exp_v = seq_valid[k] && !(rc >= k && rc <= k + LAT - 1);
            end
            tests_run++;
            if (obs_valid[c] !== exp_v) begin
                tests_failed++;
                $display("FAIL midreset_valid slot=%0d got %b want %b", c, obs_valid[c], exp_v);
            end
            if (exp_v) begin
                tests_run++;
                if (obs_b[c] !== bv4_inv_ref(seq_gamma[c-LAT])) begin
                    tests_failed++;
                    $display("FAIL midreset_data slot=%0d got %h want %h", c, obs_b[c],
                             bv4_inv_ref(seq_gamma[c-LAT]));
                end
            end
        end
        tests_run++;
        if (obs_zero[rc+1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_clear got nonzero shares want all zero");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit exp_v;
        n = 40;
        for (int k = 0; k < n; k++) begin
            seq_valid[k] = (k < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            seq_gamma[k] = bv4_t'($urandom());
            seq_theta[k] = theta_of(seq_gamma[k]);
        end
        run_stream2(n, -1);
        for (int c = LAT; c < n + LAT; c++) begin
            exp_v = seq_valid[c-LAT];
            tests_run++;
            if (obs_valid[c] !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_valid slot=%0d got %b want %b", c, obs_valid[c], exp_v);
            end
            if (exp_v) begin
                tests_run++;
                if (obs_b[c] !== bv4_inv_ref(seq_gamma[c-LAT])) begin
                    tests_failed++;
                    $display("FAIL b2b_data slot=%0d g=%h got %h want %h", c, seq_gamma[c-LAT],
                             obs_b[c], bv4_inv_ref(seq_gamma[c-LAT]));
                end
            end
        end
    endtask

    task automatic test_mask_independence();
        int n;
        bv4_t want;
        bv4_t first [0:NS3-1];
        bit   varied [0:NS3-1];
        n = 1000;
        want = bv4_inv_ref(4'h7);
        for (int i = 0; i < NS3; i++) varied[i] = 1'b0;
        for (int c = 0; c < n + LAT; c++) begin
            @(negedge clk);
            if (c >= LAT) begin
                tests_run++;
                if (ov3 !== 1'b1 || unmask3(b3) !== want) begin
                    tests_failed++;
                    $display("FAIL mask_indep slot=%0d got valid=%b value=%h want valid=1 value=%h",
                             c, ov3, unmask3(b3), want);
                end
                for (int i = 0; i < NS3; i++) begin
                    if (c == LAT) first[i] = b3[i];
                    else if (b3[i] !== first[i]) varied[i] = 1'b1;
                end
            end
            valid3 = (c < n);
            gamma3 = mask_g3(4'h7);
            theta3 = (c >= 1 && c - 1 < n) ? mask_t3(theta_of(4'h7)) : t3_t'($urandom());
            rnd3   = NR3'($urandom());
        end
        for (int i = 0; i < NS3; i++) begin
            tests_run++;
            if (varied[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL mask_share_constant share=%0d got constant %h want varying", i, first[i]);
            end
        end
        idle3();
    endtask

    initial begin
        rst = 1'b1;
        valid2 = 1'b0; gamma2 = '0; theta2 = '0; rnd2 = '0;
        idle3();
        test_reset();
        test_zero_theta();
        test_exhaustive();
        test_bubbles();
        test_mid_reset();
        test_back_to_back();
        test_mask_independence();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
